// File: rtl/vls_lanes.sv
// Multi-lane vector load/store unit: strided address generation, one masked
// memory request register, and an in-order load tag/data queue feeding writeback.
module vls_lanes #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 32,
    parameter int unsigned VRW      = 5,
    parameter int unsigned QDEPTH   = 4,
    parameter logic [6:0]  OP_LOAD  = 7'b0000111,
    parameter logic [6:0]  OP_STORE = 7'b0100111
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [6:0]          op,
    input  logic [AW-1:0]       rs1,
    input  logic [AW-1:0]       imm,
    input  logic                row_col,
    input  logic [4:0]          num_rows,
    input  logic [4:0]          num_cols,
    input  logic [VRW-1:0]      vd,
    input  logic [LANES*DW-1:0] store_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [LANES*AW-1:0] mem_req_addr,
    output logic [LANES-1:0]    mem_req_mask,
    output logic [LANES*DW-1:0] mem_req_wdata,
    input  logic                mem_rsp_valid,
    input  logic [LANES*DW-1:0] mem_rsp_data,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [VRW-1:0]      wb_vd,
    output logic [LANES*DW-1:0] wb_data,
    output logic [LANES-1:0]    wb_mask,
    output logic                store_done,
    output logic                err_rsp
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic is_load, is_store, full;
    logic issue_fire, req_fire, alloc, pop, rsp_ok;

    logic [AW-1:0]       base_c, stride_c;
    logic [4:0]          len_c;
    logic [LANES*AW-1:0] addr_c;
    logic [LANES-1:0]    mask_c;

    logic                req_valid_q, req_valid_d;
    logic                req_we_q, req_we_d;
    logic [LANES*AW-1:0] req_addr_q, req_addr_d;
    logic [LANES-1:0]    req_mask_q, req_mask_d;
    logic [LANES*DW-1:0] req_wdata_q, req_wdata_d;

    logic [VRW-1:0]      q_vd_q     [QDEPTH];
    logic [VRW-1:0]      q_vd_d     [QDEPTH];
    logic [LANES-1:0]    q_mask_q   [QDEPTH];
    logic [LANES-1:0]    q_mask_d   [QDEPTH];
    logic [LANES*DW-1:0] q_data_q   [QDEPTH];
    logic [LANES*DW-1:0] q_data_d   [QDEPTH];
    logic [QDEPTH-1:0]   q_filled_q, q_filled_d;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d, rptr_q, rptr_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] pending_q, pending_d;
    logic          err_q, err_d;

    assign is_load  = (op == OP_LOAD);
    assign is_store = (op == OP_STORE);
    assign full     = (outstanding_q == CW'(QDEPTH));

    assign issue_ready = !RST && (!req_valid_q || mem_req_ready) && !(is_load && full);
    assign issue_fire  = issue_valid && issue_ready;
    assign req_fire    = req_valid_q && mem_req_ready;
    assign alloc       = issue_fire && is_load;
    assign pop         = wb_valid && wb_ready;
    // pending counts allocated entries still waiting for data; a response
    // with none pending has nowhere to land and is flagged instead.
    assign rsp_ok      = mem_rsp_valid && (pending_q != '0);

    always_comb begin
        base_c   = rs1 + imm;
        stride_c = row_col ? (AW'(num_cols) * AW'(DW / 8)) : AW'(DW / 8);
        len_c    = row_col ? num_rows : num_cols;
        addr_c   = '0;
        mask_c   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            addr_c[i*AW +: AW] = base_c + AW'(i) * stride_c;
            mask_c[i]          = (32'(len_c) > i);
        end
    end

    always_comb begin
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_mask_d  = req_mask_q;
        req_wdata_d = req_wdata_q;
        if (req_fire) req_valid_d = 1'b0;
        if (issue_fire && (is_load || is_store)) begin
            req_valid_d = 1'b1;
            req_we_d    = is_store;
            req_addr_d  = addr_c;
            req_mask_d  = mask_c;
            req_wdata_d = is_store ? store_data : '0;
        end
    end

    always_comb begin
        q_vd_d     = q_vd_q;
        q_mask_d   = q_mask_q;
        q_data_d   = q_data_q;
        q_filled_d = q_filled_q;
        head_d     = head_q + PW'(pop);
        tail_d     = tail_q + PW'(alloc);
        rptr_d     = rptr_q + PW'(rsp_ok);
        pending_d  = pending_q + CW'(alloc) - CW'(rsp_ok);
        err_d      = err_q | (mem_rsp_valid && (pending_q == '0));
        case ({alloc, pop})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase
        if (pop) q_filled_d[head_q] = 1'b0;
        if (alloc) begin
            q_vd_d[tail_q]     = vd;
            q_mask_d[tail_q]   = mask_c;
            q_data_d[tail_q]   = '0;
            q_filled_d[tail_q] = 1'b0;
        end
        if (rsp_ok) begin
            q_data_d[rptr_q]   = mem_rsp_data;
            q_filled_d[rptr_q] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            req_valid_q   <= 1'b0;
            req_we_q      <= 1'b0;
            req_addr_q    <= '0;
            req_mask_q    <= '0;
            req_wdata_q   <= '0;
            q_filled_q    <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            rptr_q        <= '0;
            outstanding_q <= '0;
            pending_q     <= '0;
            err_q         <= 1'b0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_vd_q[i]   <= '0;
                q_mask_q[i] <= '0;
                q_data_q[i] <= '0;
            end
        end else begin
            req_valid_q   <= req_valid_d;
            req_we_q      <= req_we_d;
            req_addr_q    <= req_addr_d;
            req_mask_q    <= req_mask_d;
            req_wdata_q   <= req_wdata_d;
            q_filled_q    <= q_filled_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            rptr_q        <= rptr_d;
            outstanding_q <= outstanding_d;
            pending_q     <= pending_d;
            err_q         <= err_d;
            q_vd_q        <= q_vd_d;
            q_mask_q      <= q_mask_d;
            q_data_q      <= q_data_d;
        end
    end

    assign mem_req_valid = req_valid_q;
    assign mem_req_we    = req_we_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_mask  = req_mask_q;
    assign mem_req_wdata = req_wdata_q;
    assign store_done    = req_fire && req_we_q;
    assign err_rsp       = err_q;

    assign wb_valid = (outstanding_q != '0) && q_filled_q[head_q];
    assign wb_vd    = wb_valid ? q_vd_q[head_q]   : '0;
    assign wb_data  = wb_valid ? q_data_q[head_q] : '0;
    assign wb_mask  = wb_valid ? q_mask_q[head_q] : '0;

endmodule
